// File: rtl/fp_div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fp_div_seq
//  Purpose  : Multi-cycle IEEE-754 floating-point divider (a / b).
//             Restoring radix-2 mantissa division, one quotient bit per
//             cycle. Round-to-nearest-even, special-operand handling and
//             exception flags. Subnormal inputs are flushed to zero, and
//             results that would be subnormal are also flushed to zero.
//  Ports    : clk    - clock, rising edge
//             rst    - asynchronous active-high reset
//             start  - request, sampled only while idle
//             a, b   - dividend / divisor, captured on the accepted start
//             busy   - high whenever the unit is not idle
//             done   - one-cycle pulse, result and flags valid
//             result - quotient, held until the next accepted start
//             flags  - {invalid, divzero, overflow, underflow, inexact}
//  Revision : 1.0 - initial release
// ============================================================================
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     busy,
  output logic                     done,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [4:0]               flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int Q  = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(Q + 1);

  localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIV    = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Captured operands and division datapath
  logic [W-1:0]          op_a, op_b;
  logic                  res_sign;
  logic signed [EW-1:0]  exp_acc;
  logic [MAN_W+1:0]      rem;
  logic [MAN_W:0]        mant_b;
  logic [Q-1:0]          quot;
  logic [CW-1:0]         bit_cnt;

  // Operand classification
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan;
  logic sign_res;

  assign ea = op_a[W-2:MAN_W];
  assign eb = op_b[W-2:MAN_W];
  assign fa = op_a[MAN_W-1:0];
  assign fb = op_b[MAN_W-1:0];

  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  // A zero exponent covers both true zero and flushed subnormals.
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];
  assign sign_res = op_a[W-1] ^ op_b[W-1];

  // Special-operand result, evaluated in priority order
  logic           special;
  logic [W-1:0]   spec_res;
  logic [4:0]     spec_flags;

  always_comb begin
    special    = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan | b_nan) begin
      spec_res      = QNAN;
      spec_flags[4] = a_snan | b_snan;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_res      = QNAN;
      spec_flags[4] = 1'b1;
    end else if (b_zero & ~a_inf) begin
      spec_res      = {sign_res, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags[3] = 1'b1;
    end else if (a_inf) begin
      spec_res      = {sign_res, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero | b_inf) begin
      spec_res      = {sign_res, {(W-1){1'b0}}};
    end else begin
      special       = 1'b0;
    end
  end

  // One restoring step
  logic             rem_ge;
  logic [MAN_W+1:0] rem_sub;

  assign rem_ge  = rem >= {1'b0, mant_b};
  assign rem_sub = rem_ge ? (rem - {1'b0, mant_b}) : rem;

  // Normalise and round
  logic [Q-1:0]         qn;
  logic signed [EW-1:0] e_norm, e_fin;
  logic [MAN_W:0]       mant;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     frac_out;
  logic                 guard, rnd, sticky, inc, inexact;
  logic [W-1:0]         rnd_res;
  logic [4:0]           rnd_flags;

  always_comb begin
    // Quotient lies in (0.5, 2); a clear MSB means one left shift.
    qn       = quot[Q-1] ? quot : {quot[Q-2:0], 1'b0};
    e_norm   = quot[Q-1] ? exp_acc : (exp_acc - EW'(1));
    mant     = qn[Q-1:2];
    guard    = qn[1];
    rnd      = qn[0];
    sticky   = |rem;
    inc      = guard & (rnd | sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    frac_out = mant_r[MAN_W-1:0];
    e_fin    = e_norm;
    if (mant_r[MAN_W+1]) begin
      frac_out = mant_r[MAN_W:1];
      e_fin    = e_norm + EW'(1);
    end
    inexact   = guard | rnd | sticky;
    rnd_res   = {res_sign, e_fin[EXP_W-1:0], frac_out};
    rnd_flags = {4'b0000, inexact};
    if (e_fin >= EMAX) begin
      rnd_res   = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 5'b00101;
    end else if (e_fin[EW-1] || (e_fin == '0)) begin
      rnd_res   = {res_sign, {(W-1){1'b0}}};
      rnd_flags = 5'b00011;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE:   if (start) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = special ? S_DONE : S_DIV;
      S_DIV:    if (bit_cnt == CW'(Q - 1)) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      res_sign <= 1'b0;
      exp_acc  <= '0;
      rem      <= '0;
      mant_b   <= '0;
      quot     <= '0;
      bit_cnt  <= '0;
      result   <= '0;
      flags    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a <= a;
            op_b <= b;
          end
        end
        S_UNPACK: begin
          res_sign <= sign_res;
          if (special) begin
            result <= spec_res;
            flags  <= spec_flags;
          end else begin
            rem     <= {1'b0, 1'b1, fa};
            mant_b  <= {1'b1, fb};
            exp_acc <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
            quot    <= '0;
            bit_cnt <= '0;
          end
        end
        S_DIV: begin
          quot    <= {quot[Q-2:0], rem_ge};
          rem     <= rem_sub << 1;
          bit_cnt <= bit_cnt + CW'(1);
        end
        S_ROUND: begin
          result <= rnd_res;
          flags  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fp_div_seq
//  Purpose  : Self-checking bench for fp_div_seq, single and half precision.
//             Expected results are queued when an operation is launched and
//             compared when the matching done pulse appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_seq;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [31:0] res32;
  logic [4:0]  flags32;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [15:0] res16;
  logic [4:0]  flags16;

  int checks = 0;
  int errors = 0;
  int done_cnt32 = 0;
  exp_t q32[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .flags(flags32)
  );

  fp_div_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .flags(flags16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard monitors
  initial begin : mon32
    exp_t e;
    forever begin
      @(negedge clk);
      if (done32) begin
        done_cnt32++;
        check("sb32_depth", 32'(q32.size()), 32'd1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          check("res32", res32, e.res);
          check("flags32", {27'd0, flags32}, {27'd0, e.flg});
        end
      end
    end
  end

  initial begin : mon16
    exp_t e;
    forever begin
      @(negedge clk);
      if (done16) begin
        check("sb16_depth", 32'(q16.size()), 32'd1);
        if (q16.size() != 0) begin
          e = q16.pop_front();
          check("res16", {16'd0, res16}, e.res);
          check("flags16", {27'd0, flags16}, {27'd0, e.flg});
        end
      end
    end
  end

  // Launch one operation, measure latency, optionally poke start mid-run
  // (poke = edge index) and/or during the done cycle.
  task automatic run(input bit h, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] er, input logic [4:0] ef, input int lat,
                     input int poke, input bit poke_done, input string tag);
    exp_t e;
    int   n;
    bit   seen;
    bit   busy_ok;
    e.res = er;
    e.flg = ef;
    @(negedge clk);
    if (h) begin
      q16.push_back(e); a16 = av[15:0]; b16 = bv[15:0]; start16 = 1'b1;
    end else begin
      q32.push_back(e); a32 = av; b32 = bv; start32 = 1'b1;
    end
    @(posedge clk); #1;
    start32 = 1'b0; start16 = 1'b0;
    n = 1; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < 200) begin
      if (!(h ? busy16 : busy32)) busy_ok = 1'b0;
      if (h ? done16 : done32) begin
        seen = 1'b1;
      end else begin
        if (n == poke) begin
          if (h) begin a16 = ~av[15:0]; b16 = ~bv[15:0]; start16 = 1'b1; end
          else begin a32 = ~av; b32 = ~bv; start32 = 1'b1; end
        end
        @(posedge clk); #1;
        start32 = 1'b0; start16 = 1'b0;
        n++;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    if (!seen) begin
      if (h && q16.size() != 0) void'(q16.pop_front());
      if (!h && q32.size() != 0) void'(q32.pop_front());
    end
    if (seen && poke_done) begin
      if (h) start16 = 1'b1; else start32 = 1'b1;
    end
    @(negedge clk);
    if (poke_done) begin
      @(posedge clk); #1;
      start32 = 1'b0; start16 = 1'b0;
      check({tag, "_start_in_done_ignored"}, {31'd0, (h ? busy16 : busy32)}, 32'd0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int saved;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy32", {31'd0, busy32}, 32'd0);
    check("rst_done32", {31'd0, done32}, 32'd0);
    check("rst_res32", res32, 32'd0);
    check("rst_flags32", {27'd0, flags32}, 32'd0);
    check("rst_busy16", {31'd0, busy16}, 32'd0);
    check("rst_res16", {16'd0, res16}, 32'd0);
    rst = 1'b0;

    // Normal path
    run(0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, 0, 0, "six_by_two");
    run(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29, 0, 0, "one_third");
    run(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 29, 0, 1, "one_by_one");
    run(0, 32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, 29, 0, 0, "two_thirds");
    run(0, 32'hC0C00000, 32'h40800000, 32'hBFC00000, 5'b00000, 29, 0, 0, "neg_six_by_four");

    // Special operands
    run(0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2, 0, 0, "div_zero");
    run(0, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2, 0, 0, "zero_zero");
    run(0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 2, 0, 0, "snan");
    run(0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000, 2, 0, 0, "qnan");
    run(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2, 0, 0, "ninf_by_two");
    run(0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 2, 0, 0, "inf_inf");
    run(0, 32'h40000000, 32'hFF800000, 32'h80000000, 5'b00000, 2, 0, 0, "two_by_ninf");
    run(0, 32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 2, 0, 0, "nzero_by_two");
    run(0, 32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, 2, 0, 0, "subnormal_in");

    // Range limits
    run(0, 32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 5'b00101, 29, 0, 0, "overflow");
    run(0, 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 29, 0, 0, "underflow_pos");
    run(0, 32'h80800000, 32'h40000000, 32'h80000000, 5'b00011, 29, 0, 0, "underflow_neg");

    // Start while busy is ignored
    run(0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, 5, 0, "busy_start");

    // Reset mid-operation
    @(negedge clk);
    a32 = 32'h3F800000; b32 = 32'h40400000; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy32}, 32'd0);
    check("abort_done", {31'd0, done32}, 32'd0);
    check("abort_res", res32, 32'd0);
    check("abort_flags", {27'd0, flags32}, 32'd0);
    saved = done_cnt32;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    check("abort_no_done", 32'(done_cnt32), 32'(saved));

    // Normal operation after reset
    run(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29, 0, 0, "after_reset");

    // Half precision
    run(1, 32'h00004600, 32'h00004000, 32'h00004200, 5'b00000, 16, 0, 0, "h_six_by_two");
    run(1, 32'h00003C00, 32'h00004200, 32'h00003555, 5'b00001, 16, 0, 0, "h_one_third");
    run(1, 32'h00003C00, 32'h00000000, 32'h00007C00, 5'b01000, 2, 0, 0, "h_div_zero");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
